// File: rtl/dfr_core_ctrl_pkg.sv
// dfr_core_ctrl_pkg: shared types and helpers for the DFR run sequencer.
// Holds the FSM state type, memory-select codes and the sat_shift helper.
package dfr_core_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CFG,
    IN_RD,
    RES_IN,
    RES_WAIT,
    MAC_RD,
    MAC_ACC,
    MAC_WR,
    DONE
  } state_e;

  localparam logic [7:0] MEM_INPUT  = 8'h00;
  localparam logic [7:0] MEM_RES    = 8'h10;
  localparam logic [7:0] MEM_WEIGHT = 8'h20;
  localparam logic [7:0] MEM_OUT    = 8'h30;

  localparam int SAT_W = 128;

  // Arithmetic shift right by frac, then clamp to the signed dw-bit range.
  function automatic logic signed [SAT_W-1:0] sat_shift(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac,
    input int                      dw
  );
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sh = acc >>> frac;
    hi = $signed((SAT_W'(1) << (dw - 1)) - SAT_W'(1));
    lo = ~hi;
    if (sh > hi)
      return hi;
    else if (sh < lo)
      return lo;
    else
      return sh;
  endfunction

endpackage

// File: rtl/dfr_core_ctrl_if.sv
// dfr_core_ctrl_if: memory and reservoir bus owned by the sequencer.
// master = sequencer side, slave = memories + reservoir side.
interface dfr_core_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 20
);

  logic          in_mem_rd_en;
  logic [AW-1:0] in_mem_rd_addr;
  logic [DW-1:0] in_mem_rd_data;

  logic          res_in_valid;
  logic [DW-1:0] res_in_data;
  logic          res_out_valid;
  logic [DW-1:0] res_out_data;

  logic          rmem_wr_en;
  logic          rmem_rd_en;
  logic [AW-1:0] rmem_addr;
  logic [DW-1:0] rmem_wr_data;
  logic [DW-1:0] rmem_rd_data;

  logic          wmem_rd_en;
  logic [AW-1:0] wmem_rd_addr;
  logic [DW-1:0] wmem_rd_data;

  logic          omem_wr_en;
  logic [AW-1:0] omem_wr_addr;
  logic [DW-1:0] omem_wr_data;

  modport master (
    output in_mem_rd_en, in_mem_rd_addr,
    input  in_mem_rd_data,
    output res_in_valid, res_in_data,
    input  res_out_valid, res_out_data,
    output rmem_wr_en, rmem_rd_en, rmem_addr,
    output rmem_wr_data,
    input  rmem_rd_data,
    output wmem_rd_en, wmem_rd_addr,
    input  wmem_rd_data,
    output omem_wr_en, omem_wr_addr, omem_wr_data
  );

  modport slave (
    input  in_mem_rd_en, in_mem_rd_addr,
    output in_mem_rd_data,
    input  res_in_valid, res_in_data,
    output res_out_valid, res_out_data,
    input  rmem_wr_en, rmem_rd_en, rmem_addr,
    input  rmem_wr_data,
    output rmem_rd_data,
    input  wmem_rd_en, wmem_rd_addr,
    output wmem_rd_data,
    input  omem_wr_en, omem_wr_addr, omem_wr_data
  );

endinterface

// File: rtl/dfr_core_ctrl_mac.sv
// dfr_core_ctrl_mac: signed MAC with clear, shift-by-FRAC and saturation.
// clk/rst_n, clr/en controls, a/b operands, q = sat(acc >>> FRAC).
import dfr_core_ctrl_pkg::*;

module dfr_core_ctrl_mac #(
  parameter int DW   = 32,
  parameter int FRAC = 16,
  parameter int N    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic        [DW-1:0] q
);

  localparam int ACCW = 2 * DW + $clog2(N);

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc_q;

  assign prod = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_q <= '0;
    else if (clr)
      acc_q <= '0;
    else if (en)
      acc_q <= acc_q + ACCW'(prod);
  end

  assign q = DW'(sat_shift(SAT_W'(acc_q), FRAC, DW));

endmodule

// File: rtl/dfr_core_ctrl.sv
// dfr_core_ctrl: sequencer for one DFR run (reservoir pass, then output layer).
// Ports: clock/reset, start/abort/config in, busy/done/cfg_err out, bus = memories.
import dfr_core_ctrl_pkg::*;

module dfr_core_ctrl #(
  parameter int VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 20,
  parameter int FRAC_BITS     = 16
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] num_samples,
  input  logic [ADDR_WIDTH-1:0] num_init_samples,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  dfr_core_ctrl_if.master       bus
);

  localparam int N  = VIRTUAL_NODES;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * AW;
  localparam int NB = (N > 1) ? $clog2(N) : 1;

  state_e          state_q;
  logic [AW-1:0]   s_q, i_q, t_q, b_q;
  logic [AW-1:0]   k_q, j_q, o_q;
  logic [NB-1:0]   n_q;
  logic            ovf_q;
  logic            cfg_err_q;
  logic [PW-1:0]   t_full;
  logic            k_last, n_last;
  logic            st_in_rd, st_res_in, st_wait;
  logic            st_mac_rd, st_mac_acc, st_mac_wr;
  logic [DW-1:0]   mac_q;

  // Full-width product so an S*N that does not fit AW is detectable.
  assign t_full = PW'(num_samples) * PW'(N);

  assign k_last = (k_q == t_q - 1'b1);
  assign n_last = (n_q == NB'(N - 1));

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= IDLE;
      s_q       <= '0;
      i_q       <= '0;
      t_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      j_q       <= '0;
      o_q       <= '0;
      n_q       <= '0;
      ovf_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (abort && state_q != IDLE) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          s_q       <= num_samples;
          i_q       <= num_init_samples;
          t_q       <= t_full[AW-1:0];
          ovf_q     <= |t_full[PW-1:AW];
          b_q       <= AW'(PW'(num_init_samples) * PW'(N));
          cfg_err_q <= 1'b0;
          state_q   <= CFG;
        end
        CFG: begin
          if (ovf_q || i_q > s_q) begin
            cfg_err_q <= 1'b1;
            state_q   <= DONE;
          end else if (s_q == '0) begin
            state_q <= DONE;
          end else begin
            k_q     <= '0;
            state_q <= IN_RD;
          end
        end
        IN_RD:  state_q <= RES_IN;
        RES_IN: state_q <= RES_WAIT;
        RES_WAIT: if (bus.res_out_valid) begin
          if (!k_last) begin
            k_q     <= k_q + 1'b1;
            state_q <= IN_RD;
          end else if (s_q > i_q) begin
            j_q     <= b_q;
            n_q     <= '0;
            o_q     <= '0;
            state_q <= MAC_RD;
          end else begin
            state_q <= DONE;
          end
        end
        MAC_RD: state_q <= MAC_ACC;
        MAC_ACC: begin
          j_q <= j_q + 1'b1;
          if (n_last) begin
            state_q <= MAC_WR;
          end else begin
            n_q     <= n_q + 1'b1;
            state_q <= MAC_RD;
          end
        end
        MAC_WR: begin
          n_q     <= '0;
          o_q     <= o_q + 1'b1;
          state_q <= (j_q == t_q) ? DONE : MAC_RD;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign st_in_rd   = (state_q == IN_RD);
  assign st_res_in  = (state_q == RES_IN);
  assign st_wait    = (state_q == RES_WAIT);
  assign st_mac_rd  = (state_q == MAC_RD);
  assign st_mac_acc = (state_q == MAC_ACC);
  assign st_mac_wr  = (state_q == MAC_WR);

  // Accumulator is held only across one output's MAC_RD/MAC_ACC loop.
  dfr_core_ctrl_mac #(
    .DW   (DW),
    .FRAC (FRAC_BITS),
    .N    (N)
  ) u_mac (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .clr   (!(st_mac_rd || st_mac_acc)),
    .en    (st_mac_acc),
    .a     (bus.rmem_rd_data),
    .b     (bus.wmem_rd_data),
    .q     (mac_q)
  );

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign cfg_err = cfg_err_q;

  assign bus.in_mem_rd_en   = st_in_rd;
  assign bus.in_mem_rd_addr = st_in_rd ? k_q : '0;

  assign bus.res_in_valid = st_res_in;
  assign bus.res_in_data  = st_res_in ? bus.in_mem_rd_data : '0;

  assign bus.rmem_wr_en   = st_wait && bus.res_out_valid;
  assign bus.rmem_rd_en   = st_mac_rd;
  assign bus.rmem_addr    = bus.rmem_wr_en ? k_q :
                            st_mac_rd      ? j_q : '0;
  assign bus.rmem_wr_data = bus.rmem_wr_en ? bus.res_out_data : '0;

  assign bus.wmem_rd_en   = st_mac_rd;
  assign bus.wmem_rd_addr = st_mac_rd ? AW'(n_q) : '0;

  assign bus.omem_wr_en   = st_mac_wr;
  assign bus.omem_wr_addr = st_mac_wr ? o_q : '0;
  assign bus.omem_wr_data = st_mac_wr ? mac_q : '0;

endmodule

// File: tb/tb_dfr_core_ctrl.sv
// tb_dfr_core_ctrl: scoreboard bench for dfr_core_ctrl.
// Memories and a delay-line reservoir are modelled here; writes are checked in order.
module tb_dfr_core_ctrl;

  localparam int N     = 10;
  localparam int DW    = 32;
  localparam int AW    = 20;
  localparam int FB    = 16;
  localparam int DEPTH = 128;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] num_samples = '0;
  logic [AW-1:0] num_init_samples = '0;
  logic          busy, done, cfg_err;

  always #5 clk = ~clk;

  dfr_core_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  dfr_core_ctrl #(
    .VIRTUAL_NODES (N),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .FRAC_BITS     (FB)
  ) dut (
    .S_AXI_ACLK       (clk),
    .S_AXI_ARESETN    (rst_n),
    .start            (start),
    .abort            (abort),
    .num_samples      (num_samples),
    .num_init_samples (num_init_samples),
    .busy             (busy),
    .done             (done),
    .cfg_err          (cfg_err),
    .bus              (bus)
  );

  logic [DW-1:0] in_mem [DEPTH];
  logic [DW-1:0] rmem   [DEPTH];
  logic [DW-1:0] wmem   [DEPTH];
  logic [DW-1:0] mask = '0;
  int            lat  = 2;

  always @(posedge clk) begin
    if (bus.in_mem_rd_en)
      bus.in_mem_rd_data <= in_mem[int'(bus.in_mem_rd_addr) % DEPTH];
    if (bus.rmem_wr_en)
      rmem[int'(bus.rmem_addr) % DEPTH] <= bus.rmem_wr_data;
    if (bus.rmem_rd_en)
      bus.rmem_rd_data <= rmem[int'(bus.rmem_addr) % DEPTH];
    if (bus.wmem_rd_en)
      bus.wmem_rd_data <= wmem[int'(bus.wmem_rd_addr) % DEPTH];
  end

  // Reservoir stand-in: out = in ^ mask after lat cycles.
  logic          pipe_v [8];
  logic [DW-1:0] pipe_d [8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int q = 0; q < 8; q++) begin
        pipe_v[q] <= 1'b0;
        pipe_d[q] <= '0;
      end
    end else begin
      pipe_v[0] <= bus.res_in_valid;
      pipe_d[0] <= bus.res_in_data ^ mask;
      for (int q = 1; q < 8; q++) begin
        pipe_v[q] <= pipe_v[q-1];
        pipe_d[q] <= pipe_d[q-1];
      end
    end
  end

  assign bus.res_out_valid = pipe_v[lat-1];
  assign bus.res_out_data  = pipe_d[lat-1];

  int  checks = 0;
  int  passes = 0;
  int  done_seen = 0;
  bit  wr_block = 1'b0;
  wr_t exp_r[$];
  wr_t exp_o[$];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm, input logic [63:0] act);
    checks++;
    $display("FAIL %s: got %0h expected none", nm, act);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (done)
        done_seen++;
      if (bus.rmem_wr_en) begin
        if (wr_block || exp_r.size() == 0) begin
          fail("rmem_extra_wr", 64'(bus.rmem_addr));
        end else begin
          e = exp_r.pop_front();
          check("rmem_addr", 64'(bus.rmem_addr), 64'(e.a));
          check("rmem_data", 64'(bus.rmem_wr_data), 64'(e.d));
        end
      end
      if (bus.omem_wr_en) begin
        if (wr_block || exp_o.size() == 0) begin
          fail("omem_extra_wr", 64'(bus.omem_wr_addr));
        end else begin
          e = exp_o.pop_front();
          check("omem_addr", 64'(bus.omem_wr_addr), 64'(e.a));
          check("omem_data", 64'(bus.omem_wr_data), 64'(e.d));
        end
      end
    end
  end

  // Reference: every sample goes through the reservoir; samples I..S-1
  // each produce sat32((sum_n r[s*N+n]*w[n]) >>> 16).
  task automatic push_model(input int s, input int i);
    wr_t                     e;
    logic signed [DW-1:0]    r, w;
    logic signed [127:0]     acc, sh;
    longint                  p;
    for (int k = 0; k < s * N; k++) begin
      e.a = AW'(k);
      e.d = in_mem[k] ^ mask;
      exp_r.push_back(e);
    end
    for (int sm = i; sm < s; sm++) begin
      acc = '0;
      for (int n = 0; n < N; n++) begin
        r = in_mem[sm * N + n] ^ mask;
        w = wmem[n];
        p = longint'(r) * longint'(w);
        acc = acc + p;
      end
      sh = acc >>> FB;
      if (sh > 128'sd2147483647)
        e.d = 32'h7FFF_FFFF;
      else if (sh < -128'sd2147483648)
        e.d = 32'h8000_0000;
      else
        e.d = sh[31:0];
      e.a = AW'(sm - i);
      exp_o.push_back(e);
    end
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < DEPTH; k++) begin
      case (mode)
        0:       in_mem[k] = DW'(k);
        1:       in_mem[k] = 32'h0001_0000;
        2:       in_mem[k] = 32'h7FFF_FFFF;
        3:       in_mem[k] = 32'h8000_0000;
        4:       in_mem[k] = $urandom_range(0, 32'h3FFFF) - 32'h20000;
        default: in_mem[k] = $urandom;
      endcase
    end
    for (int n = 0; n < DEPTH; n++) begin
      case (mode)
        0, 1:    wmem[n] = 32'h0001_0000;
        2, 3:    wmem[n] = 32'h7FFF_FFFF;
        4:       wmem[n] = $urandom_range(0, 32'h3FFFF) - 32'h20000;
        default: wmem[n] = $urandom;
      endcase
    end
    case (mode)
      4:       mask = DW'($urandom_range(0, 255));
      5:       mask = $urandom;
      default: mask = '0;
    endcase
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run(input int s, input int i, input bit exp_err,
                     input bit dup);
    int d0, cyc;
    bit drop;
    num_samples      = AW'(s);
    num_init_samples = AW'(i);
    if (!exp_err)
      push_model(s, i);
    d0 = done_seen;
    drop = 1'b0;
    cyc = 0;
    pulse_start();
    check("busy_after_start", 64'(busy), 64'(1));
    check("cfg_err_cleared", 64'(cfg_err), 64'(0));
    while (done_seen == d0 && cyc < 20000) begin
      @(negedge clk); #1;
      cyc++;
      if (dup)
        start = (cyc == 7);
      if (!busy)
        drop = 1'b1;
    end
    start = 1'b0;
    if (cyc >= 20000)
      fail("run_timeout", 64'(cyc));
    check("busy_held", 64'(drop), 64'(0));
    if (exp_err || s == 0)
      check("done_latency", 64'(cyc), 64'(2));
    @(negedge clk); #1;
    check("done_single", 64'(done_seen - d0), 64'(1));
    check("done_low", 64'(done), 64'(0));
    check("busy_low", 64'(busy), 64'(0));
    check("cfg_err", 64'(cfg_err), 64'(exp_err));
    check("rmem_left", 64'(exp_r.size()), 64'(0));
    check("omem_left", 64'(exp_o.size()), 64'(0));
    exp_r.delete();
    exp_o.delete();
  endtask

  task automatic wait_point(input bit in_mac, input int nodes_req);
    int cyc, nodes;
    cyc = 0;
    nodes = 0;
    while (cyc < 20000) begin
      @(negedge clk); #1;
      cyc++;
      if (in_mac && bus.rmem_rd_en === 1'b1)
        break;
      if (!in_mac && bus.res_in_valid === 1'b1) begin
        nodes++;
        if (nodes == nodes_req)
          break;
      end
    end
    if (cyc >= 20000)
      fail("wait_timeout", 64'(cyc));
  endtask

  task automatic abort_run(input int s, input int i, input bit in_mac);
    int d0;
    num_samples      = AW'(s);
    num_init_samples = AW'(i);
    push_model(s, i);
    d0 = done_seen;
    pulse_start();
    wait_point(in_mac, 4);
    @(posedge clk); #1 abort = 1'b1;
    check("busy_at_abort", 64'(busy), 64'(1));
    @(posedge clk); #1 abort = 1'b0;
    wr_block = 1'b1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    repeat (40) @(negedge clk);
    #1;
    check("abort_no_done", 64'(done_seen - d0), 64'(0));
    wr_block = 1'b0;
    exp_r.delete();
    exp_o.delete();
  endtask

  task automatic reset_run();
    num_samples      = AW'(3);
    num_init_samples = AW'(0);
    push_model(3, 0);
    pulse_start();
    wait_point(1'b0, 3);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_res_in_valid", 64'(bus.res_in_valid), 64'(0));
    check("rst_in_rd_en", 64'(bus.in_mem_rd_en), 64'(0));
    check("rst_rmem_wr_en", 64'(bus.rmem_wr_en), 64'(0));
    check("rst_omem_wr_en", 64'(bus.omem_wr_en), 64'(0));
    check("rst_cfg_err", 64'(cfg_err), 64'(0));
    exp_r.delete();
    exp_o.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int s, i;
    #1;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_cfg_err", 64'(cfg_err), 64'(0));
    check("reset_in_rd_en", 64'(bus.in_mem_rd_en), 64'(0));
    check("reset_res_in_valid", 64'(bus.res_in_valid), 64'(0));
    check("reset_rmem_en", 64'({bus.rmem_wr_en, bus.rmem_rd_en}), 64'(0));
    check("reset_wmem_omem_en", 64'({bus.wmem_rd_en, bus.omem_wr_en}),
          64'(0));
    #21 rst_n = 1'b1;

    lat = 2;
    fill(0); run(3, 0, 1'b0, 1'b0);
    fill(1); run(3, 0, 1'b0, 1'b0);
    lat = 3;
    fill(4); run(4, 2, 1'b0, 1'b1);
    lat = 1;
    fill(2); run(1, 0, 1'b0, 1'b0);
    fill(3); run(2, 0, 1'b0, 1'b0);

    run(3, 5, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #1 check("cfg_err_sticky", 64'(cfg_err), 64'(1));
    run(0, 0, 1'b0, 1'b0);
    run(104858, 0, 1'b1, 1'b0);
    run(20'hFFFFF, 3, 1'b1, 1'b0);

    repeat (6) begin
      s = $urandom_range(1, 6);
      i = $urandom_range(0, s);
      lat = $urandom_range(1, 4);
      fill($urandom_range(4, 5));
      run(s, i, 1'b0, 1'b0);
    end

    lat = 3;
    fill(4); abort_run(3, 0, 1'b0);
    fill(4); abort_run(3, 1, 1'b1);
    fill(4); reset_run();
    lat = 2;
    fill(4); run(2, 1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
